// File: rtl/usb_tx_serializer.sv
// usb_tx_serializer: byte-wide USB transmit path. Bytes arrive over a
// valid/ready handshake. Each byte is serialized LSB first, a stuff bit is
// inserted after STUFF_LIMIT consecutive data 1s, and the stream is NRZI
// encoded onto D+/D-. Every packet ends with an EOP (SE0, SE0, J).
//
// Optional feature macro: TX_SYNC_EN. When it is defined, a SYNC byte 0x80 is
// shifted out ahead of the first user byte. When it is undefined, the user
// supplies SYNC as the first byte.
//
// Ports:
//   clk          system clock
//   n_rst        asynchronous active-low reset
//   tx_data      byte to send, LSB first
//   tx_valid     tx_data/tx_last valid
//   tx_last      byte is the final byte of the packet
//   tx_ready     holding register empty (transfer on tx_valid && tx_ready)
//   tx_busy      packet in progress (state other than IDLE)
//   tx_underrun  one-cycle pulse: byte needed, none held, no tx_last seen
//   d_plus       registered D+ drive
//   d_minus      registered D- drive
module usb_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned STUFF_LIMIT  = 6
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_underrun,
  output logic       d_plus,
  output logic       d_minus
);

  localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned ONES_W = $clog2(STUFF_LIMIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(STUFF_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_STUFF,
    ST_EOP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [ONES_W-1:0] ones_q, ones_d;
  logic              level_q, level_d;
  logic [7:0]        hold_data_q, hold_data_d;
  logic              hold_last_q, hold_last_d;
  logic              hold_full_q, hold_full_d;
  logic [7:0]        shift_data_q, shift_data_d;
  logic              shift_last_q, shift_last_d;
  logic [1:0]        eop_cnt_q, eop_cnt_d;
  logic              dp_q, dp_d;
  logic              dm_q, dm_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              underrun_q, underrun_d;

  logic accept;
  logic drain;
  logic advance;
  logic bit_start;
  logic terminal;
  logic nxt_lvl;

  assign tx_ready    = ready_q;
  assign tx_busy     = busy_q;
  assign tx_underrun = underrun_q;
  assign d_plus      = dp_q;
  assign d_minus     = dm_q;

  // State and datapath registers; reset forces J and empties both buffers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      bit_idx_q    <= '0;
      ones_q       <= '0;
      level_q      <= 1'b1;
      hold_data_q  <= '0;
      hold_last_q  <= 1'b0;
      hold_full_q  <= 1'b0;
      shift_data_q <= '0;
      shift_last_q <= 1'b0;
      eop_cnt_q    <= '0;
      dp_q         <= 1'b1;
      dm_q         <= 1'b0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_idx_q    <= bit_idx_d;
      ones_q       <= ones_d;
      level_q      <= level_d;
      hold_data_q  <= hold_data_d;
      hold_last_q  <= hold_last_d;
      hold_full_q  <= hold_full_d;
      shift_data_q <= shift_data_d;
      shift_last_q <= shift_last_d;
      eop_cnt_q    <= eop_cnt_d;
      dp_q         <= dp_d;
      dm_q         <= dm_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      underrun_q   <= underrun_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    bit_idx_d    = bit_idx_q;
    ones_d       = ones_q;
    level_d      = level_q;
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    hold_full_d  = hold_full_q;
    shift_data_d = shift_data_q;
    shift_last_d = shift_last_q;
    eop_cnt_d    = eop_cnt_q;
    dp_d         = dp_q;
    dm_d         = dm_q;
    underrun_d   = 1'b0;
    drain        = 1'b0;
    advance      = 1'b0;
    nxt_lvl      = level_q;

    accept    = tx_valid && ready_q;
    bit_start = (bit_cnt_q == '0);
    terminal  = (bit_cnt_q == CNT_MAX);

    if (state_q != ST_IDLE) begin
      bit_cnt_d = terminal ? '0 : bit_cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        bit_idx_d = '0;
        if (hold_full_q) begin
`ifdef TX_SYNC_EN
          // SYNC goes first; the user byte stays held until SYNC completes.
          shift_data_d = 8'h80;
          shift_last_d = 1'b0;
`else
          shift_data_d = hold_data_q;
          shift_last_d = hold_last_q;
          drain        = 1'b1;
`endif
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // The pins change only at the start of a bit time.
        if (bit_start) begin
          if (shift_data_q[0] == 1'b0) begin
            nxt_lvl = ~level_q;
            ones_d  = '0;
          end else begin
            ones_d  = ones_q + ONES_W'(1);
          end
          level_d = nxt_lvl;
          dp_d    = nxt_lvl;
          dm_d    = ~nxt_lvl;
        end
        if (terminal) begin
          if (ones_q == ONES_MAX) begin
            state_d = ST_STUFF;
          end else begin
            advance = 1'b1;
          end
        end
      end

      ST_STUFF: begin
        if (bit_start) begin
          nxt_lvl = ~level_q;
          level_d = nxt_lvl;
          dp_d    = nxt_lvl;
          dm_d    = ~nxt_lvl;
          ones_d  = '0;
        end
        if (terminal) begin
          advance = 1'b1;
        end
      end

      ST_EOP: begin
        // Two bit times of SE0, then one bit time of J.
        if (bit_start) begin
          dp_d = (eop_cnt_q == 2'd2);
          dm_d = 1'b0;
        end
        if (terminal) begin
          if (eop_cnt_q == 2'd2) begin
            eop_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            eop_cnt_d = eop_cnt_q + 2'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Post-bit decision shared by SHIFT and STUFF: next bit, next byte or EOP.
    if (advance) begin
      if (bit_idx_q != 3'd7) begin
        shift_data_d = {1'b0, shift_data_q[7:1]};
        bit_idx_d    = bit_idx_q + 3'd1;
        state_d      = ST_SHIFT;
      end else if (shift_last_q) begin
        state_d   = ST_EOP;
        eop_cnt_d = '0;
        level_d   = 1'b1;
        ones_d    = '0;
      end else if (hold_full_q) begin
        shift_data_d = hold_data_q;
        shift_last_d = hold_last_q;
        drain        = 1'b1;
        bit_idx_d    = '0;
        state_d      = ST_SHIFT;
      end else begin
        underrun_d = 1'b1;
        state_d    = ST_EOP;
        eop_cnt_d  = '0;
        level_d    = 1'b1;
        ones_d     = '0;
      end
    end

    // Holding register: drain to the shifter, refill from the handshake.
    if (drain) begin
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_data_d = tx_data;
      hold_last_d = tx_last;
      hold_full_d = 1'b1;
    end

    ready_d = ~hold_full_d;
    busy_d  = (state_d != ST_IDLE);
  end

endmodule

// File: doc/usb_tx_serializer.md
Name: usb_tx_serializer

Overview:
- Transmit-side counterpart of the USB receive shift/unstuff path.
- Accepts packet bytes over a valid/ready handshake and serializes each byte LSB first.
- Inserts stuff bits, NRZI-encodes the stream, drives the D+/D- pins, and ends every packet with an EOP.
- Sits between the TX FIFO/packet builder and the bus drivers.

Parameters:
CLKS_PER_BIT, 8, clk cycles per USB bit time (>=2)
STUFF_LIMIT, 6, consecutive data 1s after which a 0 stuff bit is inserted

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
tx_data  input  8  byte to send, LSB transmitted first
tx_valid  input  1  tx_data/tx_last valid
tx_last  input  1  byte is final byte of packet
tx_ready  output  1  holding register empty; transfer when tx_valid&&tx_ready
tx_busy  output  1  packet in progress (any state but IDLE)
tx_underrun  output  1  one-cycle pulse: byte needed but none held and tx_last not seen
d_plus  output  1  registered D+ drive
d_minus  output  1  registered D- drive

Behaviour:
- Reset n_rst is asynchronous and active-low; clock is clk.
- Reset values:
  - state IDLE; d_plus=1, d_minus=0 (J); NRZI level=1.
  - tx_ready=1, tx_busy=0, tx_underrun=0.
  - ones counter=0, bit-time counter=0, holding register empty.
- Buffering: 8-bit holding register plus last flag, and an 8-bit shift register plus last flag, giving double buffering.
  - tx_ready = holding register empty.
  - A transfer may occur in any state, including on the same cycle the holding register is drained.
- States:
  - IDLE: holding register full -> move byte to shift register, go to SHIFT. The first bit drives the pins at the edge after the transition. Bit counter restarts at 0.
  - SHIFT: each bit is held CLKS_PER_BIT cycles. At the terminal count, one of the following applies, in priority order:
    - ones counter == STUFF_LIMIT -> go to STUFF (shift register is not advanced).
    - more bits remain in the byte -> present next bit.
    - byte done and last flag set -> go to EOP.
    - byte done and holding register full -> reload the shift register, continue with bit 0 of the new byte.
    - byte done and holding register empty -> pulse tx_underrun, go to EOP.
  - STUFF: drive one 0 bit (line toggles) for one bit time, clear the ones counter, then resume the SHIFT decision at the same point.
  - EOP: SE0 (d_plus=0, d_minus=0) for 2 bit times, then J for 1 bit time, then IDLE.
    - NRZI level is restored to 1.
    - The ones counter is cleared.
- NRZI: data 0 toggles the line level; data 1 holds it. J = {1,0}, K = {0,1}.
- Ones counter:
  - Increments on each transmitted data 1; clears on data 0 or a stuff bit.
  - Persists across byte boundaries.
  - If the final bit of the packet makes the count reach STUFF_LIMIT, the stuff bit is sent before EOP.
- Bit counter wraps at CLKS_PER_BIT-1. All pin changes occur only on bit boundaries.
- Bytes accepted during EOP are held and start a new packet from IDLE.
- An asynchronous reset mid-packet immediately forces J, drops tx_busy, and discards both buffers.

Optional Feature:
TX_SYNC_EN
- Defined: on leaving IDLE, an internal SYNC byte 0x80 (00000001 LSB first, producing KJKJKJKK) is shifted before the first user byte.
  - The first user byte waits in the holding register.
  - SYNC participates in ones counting.
- Undefined: no SYNC is generated; the user supplies SYNC as the first byte.
- Test Plan values assume TX_SYNC_EN undefined.

Test Plan:
- Reset -> d_plus=1, d_minus=0, tx_ready=1, tx_busy=0, tx_underrun=0.
- Send 0x00 with tx_last=1, CLKS_PER_BIT=8:
  - Pins K,J,K,J,K,J,K,J, each held 8 cycles.
  - Then SE0 for 16 cycles, J for 8 cycles.
  - tx_busy falls after 88 cycles of activity.
- Send 0xFF with tx_last=1:
  - J held 6 bit times, then a stuff bit to K, then K held 2 bits.
  - 9 bit times total before EOP.
- Send 0xFC then 0x0F back-to-back (second with tx_last):
  - Stuff bit inserted between bit 7 of 0xFC and bit 0 of 0x0F.
  - tx_ready never blocks the second byte.
- Send 0x55 with tx_last=0 and no further tx_valid:
  - tx_underrun pulses 1 cycle at the byte end.
  - SE0 for 2 bit times, J, then IDLE.
- Assert n_rst low during bit 3 of 0xA5:
  - Pins go to J immediately; tx_ready=1.
  - A new 0x00 packet after reset matches the 0x00 scenario exactly.
